// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS hex digits with per-digit dp/blanking,
// leading-zero suppression and PWM brightness, using inputs captured once per frame.
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int DIV_W       = 10,
  parameter int BRIGHT_W    = 3,
  parameter bit EN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lz_suppress_i,
  input  logic [BRIGHT_W-1:0]     brightness_i,
  output logic [NUM_DIGITS-1:0]   digit_enable_o,
  output logic [7:0]              digit_code_o,
  output logic                    frame_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] EN_MASK  = {NUM_DIGITS{EN_ACT_LOW}};
  localparam logic [7:0]            SEG_MASK = {8{SEG_ACT_LOW}};

  logic [DIV_W-1:0]        slot_cnt_reg;
  logic [IDX_W-1:0]        digit_idx_reg;
  logic [4*NUM_DIGITS-1:0] value_sh_reg;
  logic [NUM_DIGITS-1:0]   dp_sh_reg;
  logic [NUM_DIGITS-1:0]   blank_sh_reg;
  logic                    lz_sh_reg;
  logic [BRIGHT_W-1:0]     bright_sh_reg;
  logic                    first_frame_reg;
  logic [NUM_DIGITS-1:0]   enable_reg;
  logic [7:0]              code_reg;
  logic                    frame_reg;

  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [NUM_DIGITS:1]     zero_from;
  logic [3:0]              cur_nibble;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   enable_next;
  logic [7:0]              code_next;
  logic                    frame_next;

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
    endcase
  endfunction

  assign frame_wrap = (&slot_cnt_reg) && (digit_idx_reg == IDX_W'(NUM_DIGITS - 1));

  // zero_from[k]: nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never suppressed
  assign zero_from[NUM_DIGITS] = 1'b1;
  assign suppress[0]           = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_from[gi] = zero_from[gi+1] && (value_sh_reg[4*gi +: 4] == 4'h0);
      assign suppress[gi]  = lz_sh_reg && zero_from[gi];
    end
  endgenerate

  always_comb begin
    cur_nibble  = value_sh_reg[{digit_idx_reg, 2'b00} +: 4];
    lit         = !blank_sh_reg[digit_idx_reg] && !suppress[digit_idx_reg]
                  && (slot_cnt_reg != '0)
                  && (slot_cnt_reg[DIV_W-1 -: BRIGHT_W] <= bright_sh_reg);
    enable_next = '0;
    code_next   = 8'h00;
    if (lit) begin
      enable_next = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_reg;
      code_next   = {dp_sh_reg[digit_idx_reg], hex_font(cur_nibble)};
    end
    frame_next = (slot_cnt_reg == '0) && (digit_idx_reg == '0) && !first_frame_reg;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_cnt_reg    <= '0;
      digit_idx_reg   <= '0;
      value_sh_reg    <= '0;
      dp_sh_reg       <= '0;
      blank_sh_reg    <= '1;
      lz_sh_reg       <= 1'b0;
      bright_sh_reg   <= '0;
      first_frame_reg <= 1'b1;
      enable_reg      <= EN_MASK;
      code_reg        <= SEG_MASK;
      frame_reg       <= 1'b0;
    end else begin
      slot_cnt_reg <= slot_cnt_reg + 1'b1;
      if (&slot_cnt_reg) begin
        digit_idx_reg <= frame_wrap ? '0 : digit_idx_reg + 1'b1;
      end
      // Shadow copy only at the frame boundary keeps a frame tear-free
      if (frame_wrap) begin
        value_sh_reg    <= value_i;
        dp_sh_reg       <= dp_i;
        blank_sh_reg    <= blank_i;
        lz_sh_reg       <= lz_suppress_i;
        bright_sh_reg   <= brightness_i;
        first_frame_reg <= 1'b0;
      end
      enable_reg <= enable_next ^ EN_MASK;
      code_reg   <= code_next ^ SEG_MASK;
      frame_reg  <= frame_next;
    end
  end

  assign digit_enable_o = enable_reg;
  assign digit_code_o   = code_reg;
  assign frame_o        = frame_reg;

endmodule
